// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS control sequencer.
package ctrl_pkg;

    // State register encoding (4 bits; codes 14 and 15 are unused).
    typedef logic [3:0] state_t;

    localparam state_t StFetch  = 4'd0;
    localparam state_t StDecode = 4'd1;
    localparam state_t StMemAdr = 4'd2;
    localparam state_t StMemRd  = 4'd3;
    localparam state_t StMemWb  = 4'd4;
    localparam state_t StMemWr  = 4'd5;
    localparam state_t StExec   = 4'd6;
    localparam state_t StAluWb  = 4'd7;
    localparam state_t StBeq    = 4'd8;
    localparam state_t StAddiEx = 4'd9;
    localparam state_t StAddiWb = 4'd10;
    localparam state_t StJump   = 4'd11;
    localparam state_t StJal    = 4'd12;
    localparam state_t StJr     = 4'd13;

    // Supported opcodes and the jr funct code.
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] FN_JR   = 6'b001000;

    // Datapath mux encodings.
    localparam logic [1:0] AluAdd    = 2'b00;
    localparam logic [1:0] AluSub    = 2'b01;
    localparam logic [1:0] AluFunct  = 2'b10;

    localparam logic [1:0] SrcBReg   = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;
    localparam logic [1:0] SrcBImmSh = 2'b11;

    localparam logic [1:0] PcAlu     = 2'b00;
    localparam logic [1:0] PcAluOut  = 2'b01;
    localparam logic [1:0] PcJump    = 2'b10;
    localparam logic [1:0] PcReg     = 2'b11;

    localparam logic [1:0] DstRt     = 2'b00;
    localparam logic [1:0] DstRd     = 2'b01;
    localparam logic [1:0] DstRa     = 2'b10;

    localparam logic [1:0] WbAlu     = 2'b00;
    localparam logic [1:0] WbMem     = 2'b01;
    localparam logic [1:0] WbPc      = 2'b10;

    // Every control output except the debug state view.
    typedef struct packed {
        logic       pc_en;
        logic       i_or_d;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       instr_done;
        logic       illegal;
    } ctrl_out_t;

    function automatic logic op_supported(input logic [5:0] op);
        return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_JAL};
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Bundle between the multicycle controller and its datapath.
interface multicycle_ctrl_if #(
    parameter int unsigned OPW = 6,
    parameter int unsigned FNW = 6
);
    logic [OPW-1:0] opcode;
    logic [FNW-1:0] funct;
    logic           zero;
    logic           mem_ready;
    logic           pc_en;
    logic           i_or_d;
    logic           mem_write;
    logic           ir_write;
    logic           reg_write;
    logic [1:0]     reg_dst;
    logic [1:0]     mem_to_reg;
    logic           alu_src_a;
    logic [1:0]     alu_src_b;
    logic [1:0]     alu_op;
    logic [1:0]     pc_src;
    logic           instr_done;
    logic           illegal;
    logic [3:0]     state;

    // Controller side.
    modport slave (
        input  opcode, funct, zero, mem_ready,
        output pc_en, i_or_d, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, alu_op, pc_src, instr_done, illegal, state
    );

    // Datapath side.
    modport master (
        output opcode, funct, zero, mem_ready,
        input  pc_en, i_or_d, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, alu_op, pc_src, instr_done, illegal, state
    );
endinterface

// File: rtl/multicycle_ctrl_out_dec.sv
// Moore output decode: state (plus mem_ready in the memory-wait states) to strobes.
module ctrl_out_dec
    import ctrl_pkg::*;
(
    input  logic      rst,
    input  state_t    state,
    input  logic      mem_ready,
    input  logic      zero,
    input  logic      illegal_op,
    output ctrl_out_t ctrl
);

    logic pc_write;
    logic branch;

    // Per-state strobes; everything is forced low while reset is held.
    always_comb begin
        ctrl     = '0;
        pc_write = 1'b0;
        branch   = 1'b0;
        case (state)
            StFetch: begin
                ctrl.alu_src_b = SrcBFour;
                ctrl.alu_op    = AluAdd;
                ctrl.pc_src    = PcAlu;
                ctrl.ir_write  = mem_ready;
                pc_write       = mem_ready;
            end
            StDecode: begin
                // Branch target lands in ALUOut ahead of BEQ.
                ctrl.alu_src_b  = SrcBImmSh;
                ctrl.alu_op     = AluAdd;
                ctrl.illegal    = illegal_op;
                ctrl.instr_done = illegal_op;
            end
            StMemAdr, StAddiEx: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SrcBImm;
                ctrl.alu_op    = AluAdd;
            end
            StMemRd: ctrl.i_or_d = 1'b1;
            StMemWb: begin
                ctrl.reg_dst    = DstRt;
                ctrl.mem_to_reg = WbMem;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            StMemWr: begin
                ctrl.i_or_d     = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            StExec: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SrcBReg;
                ctrl.alu_op    = AluFunct;
            end
            StAluWb: begin
                ctrl.reg_dst    = DstRd;
                ctrl.mem_to_reg = WbAlu;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            StBeq: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SrcBReg;
                ctrl.alu_op     = AluSub;
                ctrl.pc_src     = PcAluOut;
                branch          = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            StAddiWb: begin
                ctrl.reg_dst    = DstRt;
                ctrl.mem_to_reg = WbAlu;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            StJump: begin
                ctrl.pc_src     = PcJump;
                pc_write        = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            StJal: begin
                // PC already holds PC+4, which is the return address for r31.
                ctrl.pc_src     = PcJump;
                pc_write        = 1'b1;
                ctrl.reg_dst    = DstRa;
                ctrl.mem_to_reg = WbPc;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            StJr: begin
                ctrl.pc_src     = PcReg;
                pc_write        = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ;
        endcase
        ctrl.pc_en = pc_write | (branch & zero);
        if (!rst) begin
            ctrl = '0;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control sequencer: state register and next-state logic.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned OPW = 6,
    parameter int unsigned FNW = 6
) (
    input logic               CLK,
    input logic               rst,
    multicycle_ctrl_if.slave  bus
);

    state_t         state_q;
    state_t         state_d;
    logic [OPW-1:0] opcode;
    logic [FNW-1:0] funct;
    logic           illegal_op;
    ctrl_out_t      ctrl;

    assign opcode     = bus.opcode;
    assign funct      = bus.funct;
    assign illegal_op = !op_supported(6'(opcode));

    // State register with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing; mem_ready only matters in the memory-wait states.
    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch:  state_d = bus.mem_ready ? StDecode : StFetch;
            StDecode: begin
                if (opcode == OPW'(OP_LW) || opcode == OPW'(OP_SW)) begin
                    state_d = StMemAdr;
                end else if (opcode == OPW'(OP_R)) begin
                    state_d = (funct == FNW'(FN_JR)) ? StJr : StExec;
                end else if (opcode == OPW'(OP_BEQ)) begin
                    state_d = StBeq;
                end else if (opcode == OPW'(OP_ADDI)) begin
                    state_d = StAddiEx;
                end else if (opcode == OPW'(OP_J)) begin
                    state_d = StJump;
                end else if (opcode == OPW'(OP_JAL)) begin
                    state_d = StJal;
                end else begin
                    state_d = StFetch;
                end
            end
            StMemAdr: state_d = (opcode == OPW'(OP_LW)) ? StMemRd : StMemWr;
            StMemRd:  state_d = bus.mem_ready ? StMemWb : StMemRd;
            StMemWr:  state_d = bus.mem_ready ? StFetch : StMemWr;
            StExec:   state_d = StAluWb;
            StAddiEx: state_d = StAddiWb;
            default:  state_d = StFetch;
        endcase
    end

    ctrl_out_dec u_out_dec (
        .rst        (rst),
        .state      (state_q),
        .mem_ready  (bus.mem_ready),
        .zero       (bus.zero),
        .illegal_op (illegal_op),
        .ctrl       (ctrl)
    );

    assign bus.pc_en      = ctrl.pc_en;
    assign bus.i_or_d     = ctrl.i_or_d;
    assign bus.mem_write  = ctrl.mem_write;
    assign bus.ir_write   = ctrl.ir_write;
    assign bus.reg_write  = ctrl.reg_write;
    assign bus.reg_dst    = ctrl.reg_dst;
    assign bus.mem_to_reg = ctrl.mem_to_reg;
    assign bus.alu_src_a  = ctrl.alu_src_a;
    assign bus.alu_src_b  = ctrl.alu_src_b;
    assign bus.alu_op     = ctrl.alu_op;
    assign bus.pc_src     = ctrl.pc_src;
    assign bus.instr_done = ctrl.instr_done;
    assign bus.illegal    = ctrl.illegal;
    // The debug view reads FETCH while reset is held.
    assign bus.state      = rst ? state_q : StFetch;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: vector table, directed corners, random vs model.
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    logic CLK = 1'b0;
    logic rst;
    always #5 CLK = ~CLK;

    multicycle_ctrl_if #(.OPW(6), .FNW(6)) bus ();

    multicycle_ctrl #(.OPW(6), .FNW(6)) dut (
        .CLK (CLK),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic       pc_en;
        logic       i_or_d;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       instr_done;
        logic       illegal;
        logic [3:0] state;
    } obs_t;

    typedef enum int {
        PhFetch, PhDecode, PhMemAdr, PhMemRd, PhMemWb, PhMemWr, PhExec,
        PhAluWb, PhBeq, PhAddiEx, PhAddiWb, PhJump, PhJal, PhJr
    } ph_e;

    typedef struct {
        logic       r;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic       rdy;
        obs_t       exp;
        string      name;
    } vec_t;

    typedef struct {
        ph_e  ph;
        logic rdy;
    } step_t;

    int n_pass  = 0;
    int n_total = 0;

    // Expected outputs of one instruction phase, straight from the state table.
    function automatic obs_t expect_out(ph_e ph, logic rdy, logic z, logic bad);
        obs_t e = '0;
        case (ph)
            PhFetch:  begin e.state = StFetch; e.alu_src_b = 2'b01;
                            e.ir_write = rdy; e.pc_en = rdy; end
            PhDecode: begin e.state = StDecode; e.alu_src_b = 2'b11;
                            e.illegal = bad; e.instr_done = bad; end
            PhMemAdr: begin e.state = StMemAdr; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
            PhMemRd:  begin e.state = StMemRd; e.i_or_d = 1'b1; end
            PhMemWb:  begin e.state = StMemWb; e.mem_to_reg = 2'b01; e.reg_write = 1'b1;
                            e.instr_done = 1'b1; end
            PhMemWr:  begin e.state = StMemWr; e.i_or_d = 1'b1; e.mem_write = 1'b1;
                            e.instr_done = rdy; end
            PhExec:   begin e.state = StExec; e.alu_src_a = 1'b1; e.alu_op = 2'b10; end
            PhAluWb:  begin e.state = StAluWb; e.reg_dst = 2'b01; e.reg_write = 1'b1;
                            e.instr_done = 1'b1; end
            PhBeq:    begin e.state = StBeq; e.alu_src_a = 1'b1; e.alu_op = 2'b01;
                            e.pc_src = 2'b01; e.pc_en = z; e.instr_done = 1'b1; end
            PhAddiEx: begin e.state = StAddiEx; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
            PhAddiWb: begin e.state = StAddiWb; e.reg_write = 1'b1; e.instr_done = 1'b1; end
            PhJump:   begin e.state = StJump; e.pc_src = 2'b10; e.pc_en = 1'b1;
                            e.instr_done = 1'b1; end
            PhJal:    begin e.state = StJal; e.pc_src = 2'b10; e.pc_en = 1'b1;
                            e.reg_dst = 2'b10; e.mem_to_reg = 2'b10; e.reg_write = 1'b1;
                            e.instr_done = 1'b1; end
            PhJr:     begin e.state = StJr; e.pc_src = 2'b11; e.pc_en = 1'b1;
                            e.instr_done = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic obs_t reset_out();
        obs_t e = '0;
        e.state = StFetch;
        return e;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.pc_en      = bus.pc_en;
        o.i_or_d     = bus.i_or_d;
        o.mem_write  = bus.mem_write;
        o.ir_write   = bus.ir_write;
        o.reg_write  = bus.reg_write;
        o.reg_dst    = bus.reg_dst;
        o.mem_to_reg = bus.mem_to_reg;
        o.alu_src_a  = bus.alu_src_a;
        o.alu_src_b  = bus.alu_src_b;
        o.alu_op     = bus.alu_op;
        o.pc_src     = bus.pc_src;
        o.instr_done = bus.instr_done;
        o.illegal    = bus.illegal;
        o.state      = bus.state;
        return o;
    endfunction

    function automatic logic legal_op(logic [5:0] op);
        return op inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h02, 6'h03};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic drive(logic r, logic [5:0] op, logic [5:0] fn, logic z, logic rdy);
        rst           = r;
        bus.opcode    = op;
        bus.funct     = fn;
        bus.zero      = z;
        bus.mem_ready = rdy;
    endtask

    // Check one cycle at the falling edge, then move to just after the next rising edge.
    task automatic cycle_check(string name, obs_t exp);
        @(negedge CLK);
        check(name, 32'(sample()), 32'(exp));
        @(posedge CLK);
        #1;
    endtask

    function automatic vec_t mk(string name, logic r, logic [5:0] op, logic [5:0] fn,
                                logic z, logic rdy, obs_t exp);
        vec_t v;
        v.name = name; v.r = r; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.exp = exp;
        return v;
    endfunction

    vec_t  tbl[$];
    step_t plan[$];

    task automatic add_wait(ph_e ph);
        int w = $urandom_range(0, 3);
        repeat (w) plan.push_back('{ph, 1'b0});
        plan.push_back('{ph, 1'b1});
    endtask

    task automatic add_free(ph_e ph);
        plan.push_back('{ph, 1'($urandom % 2)});
    endtask

    initial begin
        logic [5:0] add_fn = 6'b100000;
        logic [5:0] bad_op = 6'b111111;
        obs_t o;
        int   cycles, n_ir, n_rw;
        logic done;

        drive(1'b0, 6'h00, 6'h00, 1'b0, 1'b0);

        // Cycle-by-cycle vectors: reset, add, beq taken/not taken, jal, jr, illegal, sw wait.
        tbl.push_back(mk("rst0",      0, OP_R,   add_fn, 0, 1, reset_out()));
        tbl.push_back(mk("rst1",      0, OP_R,   add_fn, 0, 1, reset_out()));
        tbl.push_back(mk("add_f",     1, OP_R,   add_fn, 0, 1, expect_out(PhFetch, 1, 0, 0)));
        tbl.push_back(mk("add_d",     1, OP_R,   add_fn, 0, 0, expect_out(PhDecode, 0, 0, 0)));
        tbl.push_back(mk("add_x",     1, OP_R,   add_fn, 0, 0, expect_out(PhExec, 0, 0, 0)));
        tbl.push_back(mk("add_wb",    1, OP_R,   add_fn, 0, 0, expect_out(PhAluWb, 0, 0, 0)));
        tbl.push_back(mk("beq1_f",    1, OP_BEQ, 6'h00,  1, 1, expect_out(PhFetch, 1, 1, 0)));
        tbl.push_back(mk("beq1_d",    1, OP_BEQ, 6'h00,  1, 1, expect_out(PhDecode, 1, 1, 0)));
        tbl.push_back(mk("beq1_b",    1, OP_BEQ, 6'h00,  1, 0, expect_out(PhBeq, 0, 1, 0)));
        tbl.push_back(mk("beq0_f",    1, OP_BEQ, 6'h00,  0, 1, expect_out(PhFetch, 1, 0, 0)));
        tbl.push_back(mk("beq0_d",    1, OP_BEQ, 6'h00,  0, 1, expect_out(PhDecode, 1, 0, 0)));
        tbl.push_back(mk("beq0_b",    1, OP_BEQ, 6'h00,  0, 1, expect_out(PhBeq, 1, 0, 0)));
        tbl.push_back(mk("jal_f",     1, OP_JAL, 6'h00,  0, 1, expect_out(PhFetch, 1, 0, 0)));
        tbl.push_back(mk("jal_d",     1, OP_JAL, 6'h00,  0, 0, expect_out(PhDecode, 0, 0, 0)));
        tbl.push_back(mk("jal_j",     1, OP_JAL, 6'h00,  0, 0, expect_out(PhJal, 0, 0, 0)));
        tbl.push_back(mk("jr_f",      1, OP_R,   FN_JR,  0, 1, expect_out(PhFetch, 1, 0, 0)));
        tbl.push_back(mk("jr_d",      1, OP_R,   FN_JR,  0, 0, expect_out(PhDecode, 0, 0, 0)));
        tbl.push_back(mk("jr_j",      1, OP_R,   FN_JR,  0, 0, expect_out(PhJr, 0, 0, 0)));
        tbl.push_back(mk("ill_f",     1, bad_op, 6'h00,  0, 1, expect_out(PhFetch, 1, 0, 0)));
        tbl.push_back(mk("ill_d",     1, bad_op, 6'h00,  0, 1, expect_out(PhDecode, 1, 0, 1)));
        tbl.push_back(mk("ill_back",  1, OP_SW,  6'h00,  0, 0, expect_out(PhFetch, 0, 0, 0)));
        tbl.push_back(mk("sw_f",      1, OP_SW,  6'h00,  0, 1, expect_out(PhFetch, 1, 0, 0)));
        tbl.push_back(mk("sw_d",      1, OP_SW,  6'h00,  0, 1, expect_out(PhDecode, 1, 0, 0)));
        tbl.push_back(mk("sw_a",      1, OP_SW,  6'h00,  0, 0, expect_out(PhMemAdr, 0, 0, 0)));
        tbl.push_back(mk("sw_wait",   1, OP_SW,  6'h00,  0, 0, expect_out(PhMemWr, 0, 0, 0)));

        @(posedge CLK);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].r, tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].rdy);
            cycle_check(tbl[i].name, tbl[i].exp);
        end

        // Reset while parked in MEMWR: everything low, then a clean fetch.
        drive(1'b0, OP_SW, 6'h00, 1'b1, 1'b1);
        cycle_check("rst_memwr0", reset_out());
        cycle_check("rst_memwr1", reset_out());
        drive(1'b1, OP_SW, 6'h00, 1'b0, 1'b1);
        cycle_check("post_rst_f", expect_out(PhFetch, 1, 0, 0));
        cycle_check("post_rst_d", expect_out(PhDecode, 1, 0, 0));
        cycle_check("post_rst_a", expect_out(PhMemAdr, 1, 0, 0));
        cycle_check("post_rst_w", expect_out(PhMemWr, 1, 0, 0));

        // lw with two FETCH waits and three MEMRD waits: ten cycles end to end.
        cycles = 0; n_ir = 0; n_rw = 0; done = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            drive(1'b1, OP_LW, 6'h00, 1'($urandom % 2), (c == 3) || (c == 9));
            @(negedge CLK);
            o = sample();
            cycles = c;
            n_ir += int'(o.ir_write);
            n_rw += int'(o.reg_write);
            done = o.instr_done;
            @(posedge CLK);
            #1;
            if (done) break;
        end
        check("lw_wait_cycles", 32'(cycles), 32'd10);
        check("lw_wait_ir_pulses", 32'(n_ir), 32'd1);
        check("lw_wait_rw_pulses", 32'(n_rw), 32'd1);

        // Random instruction stream against the phase-sequence model.
        for (int i = 0; i < 80; i++) begin
            int         k  = $urandom_range(0, 9);
            logic [5:0] op = 6'h00;
            logic [5:0] fn = 6'($urandom);
            logic       bad = 1'b0;
            plan.delete();
            add_wait(PhFetch);
            add_free(PhDecode);
            case (k)
                0: begin op = OP_LW; add_free(PhMemAdr); add_wait(PhMemRd); add_free(PhMemWb); end
                1: begin op = OP_SW; add_free(PhMemAdr); add_wait(PhMemWr); end
                3: begin op = OP_R; fn = FN_JR; add_free(PhJr); end
                4: begin op = OP_BEQ; add_free(PhBeq); end
                5: begin op = OP_ADDI; add_free(PhAddiEx); add_free(PhAddiWb); end
                6: begin op = OP_J; add_free(PhJump); end
                7: begin op = OP_JAL; add_free(PhJal); end
                8: begin
                    do op = 6'($urandom); while (legal_op(op));
                    bad = 1'b1;
                end
                default: begin
                    op = OP_R;
                    if (fn == FN_JR) fn = 6'b100010;
                    add_free(PhExec); add_free(PhAluWb);
                end
            endcase
            foreach (plan[j]) begin
                logic z = 1'($urandom % 2);
                drive(1'b1, op, fn, z, plan[j].rdy);
                cycle_check($sformatf("rnd%0d_%s", i, plan[j].ph.name()),
                            expect_out(plan[j].ph, plan[j].rdy, z, bad));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
